// File: rtl/carry4_pipe_adder.sv
// Pipelined add/subtract unit: one carry4 slice per stage, carry registered between
// stages, operand nibbles skewed in and result nibbles deskewed out.
`timescale 1ns/1ps

module carry4 (
  input  logic [3:0] S,
  input  logic [3:0] DI,
  input  logic       CI,
  input  logic       CYINIT,
  output logic [3:0] O,
  output logic [3:0] CO
);
  logic [4:0] w_c;

  // Ripple mux chain: propagate when S is set, otherwise generate from DI.
  always_comb begin
    w_c[0] = CI | CYINIT;
    for (int i = 0; i < 4; i++) begin
      w_c[i+1] = S[i] ? w_c[i] : DI[i];
    end
  end

  assign O  = S ^ w_c[3:0];
  assign CO = w_c[4:1];
endmodule

module carry4_pipe_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);
  localparam int NS = WIDTH / 4;

  logic w_adv;

  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < NS; k++) begin : g_stage
    // Stage k sees operand nibbles k..NS-1 and has already produced nibbles 0..k-1.
    localparam int RW = 4 * (NS - k);

    logic [RW-1:0]      w_aIn;
    logic [RW-1:0]      w_bIn;
    logic               w_ci;
    logic               w_vldIn;
    logic [3:0]         w_o;
    logic [3:0]         w_co;
    logic [4*(k+1)-1:0] w_sumNext;
    logic               r_vld;
    logic               r_co;
    logic [4*(k+1)-1:0] r_sum;

    if (k == 0) begin : g_head
      assign w_aIn     = in_a;
      assign w_bIn     = in_sub ? ~in_b : in_b;
      assign w_ci      = in_sub;
      assign w_vldIn   = in_valid;
      assign w_sumNext = w_o;
    end else begin : g_body
      assign w_aIn     = g_stage[k-1].g_fwd.r_aRest;
      assign w_bIn     = g_stage[k-1].g_fwd.r_bRest;
      assign w_ci      = g_stage[k-1].r_co;
      assign w_vldIn   = g_stage[k-1].r_vld;
      assign w_sumNext = {w_o, g_stage[k-1].r_sum};
    end

    carry4 u_slice (
      .S      (w_aIn[3:0] ^ w_bIn[3:0]),
      .DI     (w_aIn[3:0]),
      .CI     (w_ci),
      .CYINIT (1'b0),
      .O      (w_o),
      .CO     (w_co)
    );

    // Bubbles advance like real words; everything freezes together on backpressure.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_co  <= 1'b0;
        r_sum <= '0;
      end else if (w_adv) begin
        r_vld <= w_vldIn;
        r_co  <= w_co[3];
        r_sum <= w_sumNext;
      end
    end

    if (k < NS - 1) begin : g_fwd
      logic [RW-5:0] r_aRest;
      logic [RW-5:0] r_bRest;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_aRest <= '0;
          r_bRest <= '0;
        end else if (w_adv) begin
          r_aRest <= w_aIn[RW-1:4];
          r_bRest <= w_bIn[RW-1:4];
        end
      end
    end else begin : g_tail
      logic r_ovf;

      // Signed overflow: carry into the MSB differs from carry out of it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= w_co[3] ^ w_co[2];
        end
      end
    end
  end

  assign out_valid = g_stage[NS-1].r_vld;
  assign out_sum   = g_stage[NS-1].r_sum;
  assign out_cout  = g_stage[NS-1].r_co;
  assign out_ovf   = g_stage[NS-1].g_tail.r_ovf;
endmodule

// File: tb/tb_carry4_pipe_adder.sv
// Bench for carry4_pipe_adder: directed tables and corner sequences at WIDTH=16,
// randomized valid/ready regression at WIDTH=4 and WIDTH=32 against an arithmetic model.
`timescale 1ns/1ps

module tb_carry4_pipe_adder;
  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n4    = 0;
  int n32   = 0;

  exp_t q16[$];
  exp_t q4[$];
  exp_t q32[$];

  logic        iv16 = 1'b0, or16 = 1'b1, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ir16, ov16, cout16, ovf16;
  logic [15:0] sum16;

  logic        ivR = 1'b0, orR = 1'b1, subR = 1'b0;
  logic [31:0] aR = '0, bR = '0;
  logic        ir4, ov4, cout4, ovf4;
  logic [3:0]  sum4;
  logic        ir32, ov32, cout32, ovf32;
  logic [31:0] sum32;

  carry4_pipe_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
    .in_sub(sub16), .out_valid(ov16), .out_ready(or16), .out_sum(sum16),
    .out_cout(cout16), .out_ovf(ovf16)
  );

  carry4_pipe_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(ivR), .in_ready(ir4), .in_a(aR[3:0]), .in_b(bR[3:0]),
    .in_sub(subR), .out_valid(ov4), .out_ready(orR), .out_sum(sum4),
    .out_cout(cout4), .out_ovf(ovf4)
  );

  carry4_pipe_adder #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(ivR), .in_ready(ir32), .in_a(aR), .in_b(bR),
    .in_sub(subR), .out_valid(ov32), .out_ready(orR), .out_sum(sum32),
    .out_cout(cout32), .out_ovf(ovf32)
  );

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t refModel(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic sub);
    longint unsigned m, ua, ub;
    longint          sa, sb, sr, lim;
    exp_t            e;
    m   = (64'd1 << w) - 64'd1;
    ua  = 64'(a) & m;
    ub  = 64'(b) & m;
    if (sub) begin
      e.sum  = 32'((ua - ub) & m);
      e.cout = (ua >= ub);
    end else begin
      e.sum  = 32'((ua + ub) & m);
      e.cout = ((ua + ub) > m);
    end
    lim = longint'(64'd1 << (w - 1));
    sa  = longint'(ua);
    sb  = longint'(ub);
    if (sa >= lim) sa = sa - 2 * lim;
    if (sb >= lim) sb = sb - 2 * lim;
    sr = sub ? (sa - sb) : (sa + sb);
    e.ovf = (sr >= lim) || (sr < -lim);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic flagError(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: output word with no expected entry", name);
  endtask

  task automatic compareResult(input string tag, input exp_t e, input logic [31:0] s,
                               input logic c, input logic o);
    checkOutput({tag, ".sum"},  64'(s), 64'(e.sum));
    checkOutput({tag, ".cout"}, 64'(c), 64'(e.cout));
    checkOutput({tag, ".ovf"},  64'(o), 64'(e.ovf));
  endtask

  // One cycle on the 16-bit unit: wait an edge, drive, then score transfers at the next edge.
  task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                               input logic s, input logic r);
    exp_t e;
    @(posedge clk);
    #1;
    iv16 = v; a16 = a; b16 = b; sub16 = s; or16 = r;
    #1;
    if (v && ir16) q16.push_back(refModel(16, 32'(a), 32'(b), s));
    if (ov16 && r) begin
      if (q16.size() == 0) flagError("sb16.extra");
      else begin
        e = q16.pop_front();
        compareResult("sb16", e, 32'(sum16), cout16, ovf16);
      end
    end
  endtask

  task automatic applyStimulusRand(input logic v, input logic r, input logic [31:0] a,
                                   input logic [31:0] b, input logic s);
    exp_t e;
    @(posedge clk);
    #1;
    ivR = v; orR = r; aR = a; bR = b; subR = s;
    #1;
    if (v && ir4)  begin q4.push_back(refModel(4, a, b, s));   n4++;  end
    if (v && ir32) begin q32.push_back(refModel(32, a, b, s)); n32++; end
    if (ov4 && r) begin
      if (q4.size() == 0) flagError("sb4.extra");
      else begin
        e = q4.pop_front();
        compareResult("sb4", e, 32'(sum4), cout4, ovf4);
      end
    end
    if (ov32 && r) begin
      if (q32.size() == 0) flagError("sb32.extra");
      else begin
        e = q32.pop_front();
        compareResult("sb32", e, sum32, cout32, ovf32);
      end
    end
  endtask

  vec_t        tbl[7];
  logic [15:0] bpA[8];
  logic [15:0] bpB[8];
  logic        bpS[8];

  initial begin
    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[3] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    tbl[4] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[6] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1};

    #2;
    checkOutput("rst.held.inReady", 64'(ir16), 64'd1);
    checkOutput("rst.held.outValid", 64'(ov16), 64'd0);
    #20;
    rst = 1'b0;
    #1;
    checkOutput("idle.outValid", 64'(ov16), 64'd0);
    checkOutput("idle.outSum", 64'(sum16), 64'd0);
    checkOutput("idle.inReady", 64'(ir16), 64'd1);
    checkOutput("idle.cout", 64'(cout16), 64'd0);
    checkOutput("idle.ovf", 64'(ovf16), 64'd0);
    checkOutput("idle.sum32", 64'(sum32), 64'd0);

    $display("[TB] first word latency");
    applyStimulus(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      checkOutput($sformatf("lat.early%0d", i), 64'(ov16), 64'd0);
    end
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    checkOutput("lat.valid", 64'(ov16), 64'd1);
    checkOutput("lat.sum", 64'(sum16), 64'h0100);
    checkOutput("lat.cout", 64'(cout16), 64'd0);
    checkOutput("lat.ovf", 64'(ovf16), 64'd0);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    checkOutput("lat.oneCycle", 64'(ov16), 64'd0);

    $display("[TB] boundary table, back-to-back");
    for (int c = 0; c < 7 + 5; c++) begin
      int idx;
      if (c < 7) applyStimulus(1'b1, tbl[c].a, tbl[c].b, tbl[c].sub, 1'b1);
      else       applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      idx = c - 4;
      if (idx >= 0 && idx < 7) begin
        checkOutput($sformatf("tbl%0d.valid", idx), 64'(ov16), 64'd1);
        checkOutput($sformatf("tbl%0d.sum", idx), 64'(sum16), 64'(tbl[idx].sum));
        checkOutput($sformatf("tbl%0d.cout", idx), 64'(cout16), 64'(tbl[idx].cout));
        checkOutput($sformatf("tbl%0d.ovf", idx), 64'(ovf16), 64'(tbl[idx].ovf));
      end else begin
        checkOutput($sformatf("tbl.idle%0d", c), 64'(ov16), 64'd0);
      end
    end

    $display("[TB] backpressure");
    for (int i = 0; i < 8; i++) begin
      bpA[i] = 16'($urandom);
      bpB[i] = 16'($urandom);
      bpS[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, bpA[i], bpB[i], bpS[i], 1'b1);
    for (int s = 0; s < 5; s++) begin
      applyStimulus(1'b1, bpA[4], bpB[4], bpS[4], 1'b0);
      checkOutput($sformatf("bp.inReady%0d", s), 64'(ir16), 64'd0);
      checkOutput($sformatf("bp.valid%0d", s), 64'(ov16), 64'd1);
      if (q16.size() > 0) checkOutput($sformatf("bp.hold%0d", s), 64'(sum16), 64'(q16[0].sum[15:0]));
    end
    for (int i = 4; i < 8; i++) applyStimulus(1'b1, bpA[i], bpB[i], bpS[i], 1'b1);
    for (int i = 0; i < 20 && q16.size() > 0; i++) applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    checkOutput("bp.drained", 64'(q16.size()), 64'd0);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'($urandom) | 16'h0100, 16'($urandom), 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    checkOutput("rst.preValid", 64'(ov16), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rst.async.valid", 64'(ov16), 64'd0);
    checkOutput("rst.async.sum", 64'(sum16), 64'd0);
    checkOutput("rst.async.cout", 64'(cout16), 64'd0);
    checkOutput("rst.async.ovf", 64'(ovf16), 64'd0);
    checkOutput("rst.async.inReady", 64'(ir16), 64'd1);
    q16.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      checkOutput($sformatf("rst.noStale%0d", i), 64'(ov16), 64'd0);
    end
    applyStimulus(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      checkOutput($sformatf("rst.after.early%0d", i), 64'(ov16), 64'd0);
    end
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    checkOutput("rst.after.valid", 64'(ov16), 64'd1);
    checkOutput("rst.after.sum", 64'(sum16), 64'h0003);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

    $display("[TB] latency at WIDTH=4 and WIDTH=32");
    applyStimulusRand(1'b1, 1'b1, 32'h89AB_CDEF, 32'h1357_9BDF, 1'b0);
    applyStimulusRand(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    checkOutput("lat4.valid", 64'(ov4), 64'd1);
    checkOutput("lat32.early", 64'(ov32), 64'd0);
    for (int i = 2; i < 8; i++) begin
      applyStimulusRand(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
      checkOutput($sformatf("lat32.early%0d", i), 64'(ov32), 64'd0);
    end
    applyStimulusRand(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    checkOutput("lat32.valid", 64'(ov32), 64'd1);
    applyStimulusRand(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);

    $display("[TB] random regression");
    n4  = 0;
    n32 = 0;
    for (int cyc = 0; cyc < 60000 && (n4 < 10000 || n32 < 10000); cyc++) begin
      applyStimulusRand($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                        $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    checkOutput("rnd.words4", 64'(n4 >= 10000), 64'd1);
    checkOutput("rnd.words32", 64'(n32 >= 10000), 64'd1);
    for (int i = 0; i < 40 && (q4.size() > 0 || q32.size() > 0); i++)
      applyStimulusRand(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    checkOutput("rnd.drained4", 64'(q4.size()), 64'd0);
    checkOutput("rnd.drained32", 64'(q32.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/carry4_pipe_adder.md
# carry4_pipe_adder

Pipelined add/subtract unit built from a chain of `carry4` slices, one 4-bit slice per pipeline stage, with the carry registered between stages. It feeds operand nibbles into each slice's `S`/`DI`/`CI` inputs and collects the `O`/`CO` results into aligned output words. It sits directly upstream and downstream of the `carry4` wrapper: it drives the slice and consumes what the slice produces. It gives the datapath a full-throughput adder at one slice of carry delay per clock, with valid/ready flow control.

## Interface
- `WIDTH`, 16: operand/result width. Must be a multiple of 4, minimum 4. Number of stages `NS = WIDTH/4`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand word present.
- `in_ready`  out  1  unit accepts an operand word this cycle.
- `in_a`  in  WIDTH  operand A (unsigned or two's complement).
- `in_b`  in  WIDTH  operand B.
- `in_sub`  in  1  0: A+B; 1: A−B.
- `out_valid`  out  1  result word present.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  WIDTH  result modulo 2^WIDTH.
- `out_cout`  out  1  carry out of the MSB. For subtraction, 1 means no borrow.
- `out_ovf`  out  1  signed overflow.

## Operation
- Global advance enable `adv = ~out_valid | out_ready`. `in_ready = adv`. A transfer occurs when `in_valid & in_ready`.
- Stage k (0..NS−1) owns one `carry4` instance with `CYINIT=0`:
  - `S = a[4k+3:4k] ^ b'[4k+3:4k]`
  - `DI = a[4k+3:4k]`
  - `b' = in_sub ? ~b : b`
- Stage 0 `CI = in_sub` of the entering word. Stage k>0 `CI = registered CO[3]` of stage k−1 for the same word.
- Operand skew: nibble k of A, B′ travels through k delay registers before reaching stage k.
- Result deskew: `O` of stage k travels through NS−1−k delay registers so that all nibbles of one word emerge together.
- Each stage carries a valid bit. Stage 0 valid loads `in_valid & adv`, and valid shifts one stage per `adv` cycle. `out_valid` is the valid bit of the last stage.
- Final stage:
  - `out_cout = CO[3]`
  - `out_ovf = CO[3] ^ CO[2]` (carry into MSB xor carry out of MSB)
  - Both are registered with the result.
- When `adv=0`, every register (data, carry, valid) holds. Bubbles are not compressed; an invalid slot advances like a valid one.
- Data registers of invalid slots may hold any value. Outputs other than `out_valid` are don't-care while `out_valid=0`, but must equal 0 after reset until the first result.

## Timing
- Reset, asynchronous on `rst` assertion: all valid bits, data, carry and skew registers go to 0.
  - `out_valid=0`, `out_sum=0`, `out_cout=0`, `out_ovf=0`.
  - `in_ready=1` during and after reset, since it follows from `out_valid=0`.
- Latency: with `out_ready` held high, a word accepted at edge t appears with `out_valid=1` after edge t+NS−1. For WIDTH=16 that is 4 register stages: accepted at cycle 0, visible in cycle 4.
- Throughput: one word per cycle with `out_ready=1`.
- Backpressure: if `out_valid=1 & out_ready=0`, then `in_ready=0` in the same cycle (combinational path from `out_ready`/`out_valid`). The pipeline freezes until `out_ready` rises. The result stays stable on the output.
- Simultaneous pop and push: when `out_valid & out_ready & in_valid`, the output word leaves and the new word enters the same edge.
- Reset mid-operation: all in-flight words are discarded. No result from before reset ever appears after reset.
- Critical path: one `carry4` slice plus its input XOR/mux. No combinational carry path between stages.

## Test plan
- Reset release, idle: `out_valid=0`, `out_sum=0x0000`, `in_ready=1`. Push `in_a=0x00FF`, `in_b=0x0001`, `in_sub=0` with `out_ready=1` → exactly 4 cycles later `out_sum=0x0100`, `out_cout=0`, `out_ovf=0`, `out_valid` high for one cycle.
- Carry and overflow boundaries, streamed back-to-back:
  - 0xFFFF+0x0001 → 0x0000, cout=1, ovf=0
  - 0x7FFF+0x0001 → 0x8000, cout=0, ovf=1
  - 0x8000+0x8000 → 0x0000, cout=1, ovf=1
  - Results appear on consecutive cycles in order.
- Subtraction:
  - 0x0000−0x0001 → 0xFFFF, cout=0, ovf=0
  - 0x1234−0x1234 → 0x0000, cout=1
  - 0x8000−0x0001 → 0x7FFF, ovf=1
- Backpressure: stream 8 random words, hold `out_ready=0` for 5 cycles while the first result is valid → `in_ready=0` throughout, `out_sum` stable. On release, all 8 results emerge in order with no loss or duplication, matching a reference model.
- Reset mid-stream: assert `rst` asynchronously with 3 words in flight → outputs are 0 immediately. After release, no stale result appears. The next pushed word 0x0001+0x0002 yields 0x0003 after 4 cycles.
- Random regression, `WIDTH=4` and `WIDTH=32`: 10k random words with random `in_valid`/`out_ready` → every output matches (A±B) mod 2^WIDTH, cout and ovf, with latency NS cycles when unstalled.
